// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard command/response bytes and controller state encoding.
// Imported by the controller top and its timeout sub-module.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    SEND_RST,
    WAIT_ACK,
    WAIT_BAT,
    IDLE,
    SEND_ED,
    SEND_LED,
    ERROR
  } ps2_state_t;

  // Bytes the controller may consume as replies rather than forward as scan codes.
  function automatic logic is_response(input logic [7:0] b);
    return (b == RSP_ACK) || (b == RSP_RESEND) || (b == RSP_BAT_OK) || (b == RSP_BAT_FAIL);
  endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Response-wait timer: load to TIMEOUT_CYC, count down while enabled, saturate at zero.
// zero is combinational from the count.
module ps2_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= TW'(TIMEOUT_CYC);
    else if (en && (count != '0))
      count <= count - TW'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: reset/BAT handshake, LED writes with resend/timeout retry,
// and scan-code forwarding of every byte not consumed as a command reply.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_ready,
  input  logic       host_tx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_req,
  input  logic [2:0] led_state,
  input  logic       led_update,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       kbd_ready,
  output logic       kbd_error
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  ps2_state_t    state, state_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          led_pending, led_pending_nxt;
  logic          tx_req_nxt;
  logic [7:0]    tx_data_nxt;
  logic          tmr_load, tmr_en, tmr_zero;
  logic          retry_full;
  logic          rx_ack, rx_resend, rx_bat_ok, rx_bat_fail;
  logic          forward;

  ps2_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .en   (tmr_en),
    .zero (tmr_zero)
  );

  assign rx_ack      = host_rx_ready && (host_rx_data == RSP_ACK);
  assign rx_resend   = host_rx_ready && (host_rx_data == RSP_RESEND);
  assign rx_bat_ok   = host_rx_ready && (host_rx_data == RSP_BAT_OK);
  assign rx_bat_fail = host_rx_ready && (host_rx_data == RSP_BAT_FAIL);
  assign retry_full  = (retry == RW'(MAX_RETRY));
  assign tmr_en      = (state == WAIT_ACK) || (state == WAIT_BAT);

  assign forward = host_rx_ready && (state != ERROR) &&
                   ((state == IDLE) || !is_response(host_rx_data));

  always_comb begin
    state_nxt       = state;
    retry_nxt       = retry;
    led_pending_nxt = led_pending | led_update;
    tx_req_nxt      = 1'b0;
    tx_data_nxt     = host_tx_data;
    tmr_load        = 1'b0;
    case (state)
      SEND_RST: begin
        tx_data_nxt = CMD_RESET;
        tx_req_nxt  = 1'b1;
        tmr_load    = 1'b1;
        state_nxt   = WAIT_ACK;
      end
      SEND_ED: begin
        tx_data_nxt = CMD_SET_LED;
        tx_req_nxt  = 1'b1;
        tmr_load    = 1'b1;
        retry_nxt   = '0;
        state_nxt   = WAIT_ACK;
      end
      SEND_LED: begin
        tx_data_nxt = {5'b0, led_state[2], led_state[1], led_state[0]};
        tx_req_nxt  = 1'b1;
        tmr_load    = 1'b1;
        retry_nxt   = '0;
        state_nxt   = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The byte still on host_tx_data identifies which step is being acknowledged.
        if (rx_ack) begin
          if (host_tx_data == CMD_RESET) begin
            state_nxt = WAIT_BAT;
            tmr_load  = 1'b1;
          end else if (host_tx_data == CMD_SET_LED) begin
            state_nxt = SEND_LED;
          end else begin
            state_nxt = IDLE;
          end
        end else if (rx_resend || tmr_zero) begin
          if (retry_full) begin
            state_nxt = ERROR;
          end else begin
            retry_nxt  = retry + RW'(1);
            tx_req_nxt = 1'b1;
            tmr_load   = 1'b1;
          end
        end
      end
      WAIT_BAT: begin
        if (rx_bat_ok)
          state_nxt = IDLE;
        else if (rx_bat_fail)
          state_nxt = ERROR;
        else if (tmr_zero) begin
          if (retry_full)
            state_nxt = ERROR;
          else begin
            retry_nxt = retry + RW'(1);
            state_nxt = SEND_RST;
          end
        end
      end
      IDLE: begin
        retry_nxt = '0;
        // Pulses arriving now merge: led_state is sampled later, on SEND_LED entry.
        if (led_pending) begin
          led_pending_nxt = 1'b0;
          state_nxt       = SEND_ED;
        end
      end
      ERROR: begin
        led_pending_nxt = led_pending;
      end
      default: state_nxt = SEND_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= SEND_RST;
      retry        <= '0;
      led_pending  <= 1'b0;
      host_tx_req  <= 1'b0;
      host_tx_data <= CMD_RESET;
      scan_code    <= 8'h00;
      scan_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      retry        <= retry_nxt;
      led_pending  <= led_pending_nxt;
      host_tx_req  <= tx_req_nxt;
      host_tx_data <= tx_data_nxt;
      scan_valid   <= forward;
      if (forward)
        scan_code <= host_rx_data;
    end
  end

  // The device's line-level ACK can only follow one of our own requests.
  always_ff @(posedge clk) begin
    if (!rst && host_tx_ready)
      assert (state == WAIT_ACK);
  end

  assign kbd_ready = (state == IDLE);
  assign kbd_error = (state == ERROR);

endmodule
